if_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the program counter and issues fetches to instruction memory over a req/ack + rsp_valid handshake.

---
 rtl/if_fetch_stage_pkg.sv | 15 +
 rtl/if_fetch_stage_if.sv | 31 +++
 rtl/if_fetch_stage_pc_reg.sv | 40 ++++
 rtl/if_fetch_stage.sv | 156 +++++++++++++++
 tb/tb_if_fetch_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: datapath width, PC step,
// NOP encoding and the 2-bit fetch FSM state encodings.
package if_fetch_stage_pkg;

  localparam int unsigned IF_WIDTH     = 64;
  localparam int unsigned IF_PC_INC    = 4;
  localparam int unsigned IF_NOP_INSTR = 0;

  typedef logic [1:0] if_state_t;

  localparam if_state_t IF_S_REQ  = 2'd0;
  localparam if_state_t IF_S_WAIT = 2'd1;
  localparam if_state_t IF_S_HOLD = 2'd2;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory handshake: req/ack for the address phase, rsp_valid for data.
// master = fetch stage, slave = instruction memory.
interface if_fetch_stage_if
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned WIDTH = IF_WIDTH
) ();

  logic             p_IMEM_Req;
  logic [WIDTH-1:0] p_IMEM_Addr;
  logic             p_IMEM_Ack;
  logic             p_IMEM_Rsp_Valid;
  logic [WIDTH-1:0] p_IMEM_Rsp_Data;

  modport master (
    output p_IMEM_Req,
    output p_IMEM_Addr,
    input  p_IMEM_Ack,
    input  p_IMEM_Rsp_Valid,
    input  p_IMEM_Rsp_Data
  );

  modport slave (
    input  p_IMEM_Req,
    input  p_IMEM_Addr,
    output p_IMEM_Ack,
    output p_IMEM_Rsp_Valid,
    output p_IMEM_Rsp_Data
  );

endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter: synchronous reset, redirect load (priority) and sequential step.
// Arithmetic wraps modulo 2^WIDTH.
module if_fetch_stage_pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned      WIDTH    = IF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      PC_INC   = IF_PC_INC
) (
  input  logic             p_clk,
  input  logic             p_reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pc,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (inc) begin
      pc_d = pc_q + WIDTH'(PC_INC);
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding fetch at a time,
// buffers the returned instruction for IF/ID and drops responses made stale by redirects.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned      WIDTH    = IF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned      PC_INC   = IF_PC_INC
) (
  input  logic                p_clk,
  input  logic                p_reset,
  input  logic                p_IF_Stall,
  input  logic                p_IF_Redirect,
  input  logic [WIDTH-1:0]    p_IF_Redirect_PC,
  if_fetch_stage_if.master    imem,
  output logic [WIDTH-1:0]    p_IF_Instruction,
  output logic [WIDTH-1:0]    p_IF_PC_Counter,
  output logic                p_IF_Valid,
  output logic                p_IF_Flush_Out
);

  localparam logic [WIDTH-1:0] NopInstr = WIDTH'(IF_NOP_INSTR);

  if_state_t        state_q, state_d;
  logic             discard_q, discard_d;
  logic             buf_valid_q, buf_valid_d;
  logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] redirect_pc_aligned;
  logic             pc_inc;
  logic             consume;
  logic             req_ok;
  logic             ack;
  logic             rsp;
  logic             unused_redirect_lsb;

  assign redirect_pc_aligned = {p_IF_Redirect_PC[WIDTH-1:2], 2'b00};
  assign unused_redirect_lsb = ^p_IF_Redirect_PC[1:0];

  assign consume = buf_valid_q & ~p_IF_Stall;
  // Never request while a stalled instruction still occupies the buffer, so a
  // response can always be written without overwriting undelivered data.
  assign req_ok  = (state_q == IF_S_REQ) & (~buf_valid_q | ~p_IF_Stall);
  assign ack     = imem.p_IMEM_Ack & req_ok;
  assign rsp     = imem.p_IMEM_Rsp_Valid & (state_q == IF_S_WAIT);

  if_fetch_stage_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .p_clk   (p_clk),
    .p_reset (p_reset),
    .load    (p_IF_Redirect),
    .load_pc (redirect_pc_aligned),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    pc_inc      = 1'b0;

    if (consume) begin
      buf_valid_d = 1'b0;
      buf_instr_d = NopInstr;
    end

    if (p_IF_Redirect) begin
      buf_valid_d = 1'b0;
      buf_instr_d = NopInstr;
      case (state_q)
        IF_S_REQ: begin
          if (ack) begin
            state_d   = IF_S_WAIT;
            discard_d = 1'b1;
          end
        end
        IF_S_WAIT: begin
          // A response arriving now is the stale one; nothing else is in flight.
          if (rsp) begin
            state_d   = IF_S_REQ;
            discard_d = 1'b0;
          end else begin
            discard_d = 1'b1;
          end
        end
        default: begin
          state_d   = IF_S_REQ;
          discard_d = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        IF_S_REQ: begin
          if (ack) begin
            state_d = IF_S_WAIT;
          end
        end
        IF_S_WAIT: begin
          if (rsp) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = IF_S_REQ;
            end else begin
              buf_valid_d = 1'b1;
              buf_instr_d = imem.p_IMEM_Rsp_Data;
              buf_pc_d    = pc;
              pc_inc      = 1'b1;
              state_d     = p_IF_Stall ? IF_S_HOLD : IF_S_REQ;
            end
          end
        end
        IF_S_HOLD: begin
          if (consume) begin
            state_d = IF_S_REQ;
          end
        end
        default: begin
          state_d = IF_S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_q     <= IF_S_REQ;
      discard_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_instr_q <= NopInstr;
      buf_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  // Reset forces every output low combinationally, independent of register contents.
  assign imem.p_IMEM_Req  = req_ok & ~p_reset;
  assign imem.p_IMEM_Addr = p_reset ? '0 : pc;
  assign p_IF_Instruction = p_reset ? '0 : buf_instr_q;
  assign p_IF_PC_Counter  = p_reset ? '0 : buf_pc_q;
  assign p_IF_Valid       = buf_valid_q & ~p_reset;
  assign p_IF_Flush_Out   = p_IF_Redirect & ~p_reset;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: a memory responder plus a scoreboard that
// predicts the delivered instruction stream from fetch/redirect/reset events.
module tb_if_fetch_stage;

  typedef struct packed {
    logic [63:0] instr;
    logic [63:0] pc;
  } exp_t;

  logic        p_clk = 1'b0;
  logic        p_reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] instr_o;
  logic [63:0] pc_o;
  logic        valid_o;
  logic        flush_o;

  if_fetch_stage_if #(.WIDTH(64)) imem ();

  if_fetch_stage #(.WIDTH(64), .RESET_PC(64'h0), .PC_INC(4)) dut (
    .p_clk            (p_clk),
    .p_reset          (p_reset),
    .p_IF_Stall       (stall),
    .p_IF_Redirect    (redirect),
    .p_IF_Redirect_PC (redirect_pc),
    .imem             (imem),
    .p_IF_Instruction (instr_o),
    .p_IF_PC_Counter  (pc_o),
    .p_IF_Valid       (valid_o),
    .p_IF_Flush_Out   (flush_o)
  );

  always #5 p_clk = ~p_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [63:0] addr);
    return {addr[31:0] ^ 32'hC0DE_F00D, ~addr[31:0]};
  endfunction

  // Stimulus knobs (percent)
  int stall_pct, redir_pct, rst_pct, ack_pct, max_dly;

  // Memory responder state
  bit          pend;
  int          pend_cnt;
  logic [63:0] pend_addr;

  task automatic cycle(input bit force_reset);
    @(posedge p_clk);
    #1;
    p_reset  = force_reset || ($urandom_range(0, 99) < rst_pct);
    stall    = ($urandom_range(0, 99) < stall_pct);
    redirect = ($urandom_range(0, 99) < redir_pct);
    case ($urandom_range(0, 2))
      0:       redirect_pc = {$urandom, $urandom};
      1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      default: redirect_pc = 64'($urandom_range(0, 255));
    endcase
    imem.p_IMEM_Rsp_Valid = 1'b0;
    imem.p_IMEM_Rsp_Data  = '0;
    if (p_reset) begin
      pend = 1'b0;
    end else if (pend) begin
      if (pend_cnt == 0) begin
        imem.p_IMEM_Rsp_Valid = 1'b1;
        imem.p_IMEM_Rsp_Data  = mem_data(pend_addr);
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    #1;
    imem.p_IMEM_Ack = imem.p_IMEM_Req && ($urandom_range(0, 99) < ack_pct);
    if (imem.p_IMEM_Ack && !p_reset) begin
      pend      = 1'b1;
      pend_cnt  = $urandom_range(0, max_dly - 1);
      pend_addr = imem.p_IMEM_Addr;
    end
  endtask

  // Scoreboard / reference model
  exp_t        expq[$];
  logic [63:0] model_pc = 64'h0;
  int          gen = 0;
  int          out_gen = -1;
  logic [63:0] out_pc = 64'h0;
  int          cyc = 0;
  int          consumed = 0;
  bit          directed = 1'b1;
  int          nrec = 0;
  int          valid_cyc[3];
  logic        prev_valid = 1'b0, prev_stall = 1'b0, prev_redirect = 1'b0, prev_reset = 1'b1;
  logic [63:0] prev_instr = 64'h0, prev_pc = 64'h0;

  always @(negedge p_clk) begin
    if (p_reset) begin
      check("rst_req", 64'(imem.p_IMEM_Req), 64'h0);
      check("rst_addr", imem.p_IMEM_Addr, 64'h0);
      check("rst_instr", instr_o, 64'h0);
      check("rst_pc", pc_o, 64'h0);
      check("rst_valid", 64'(valid_o), 64'h0);
      check("rst_flush", 64'(flush_o), 64'h0);
      expq.delete();
      model_pc = 64'h0;
      gen++;
      cyc = 0;
    end else begin
      check("flush", 64'(flush_o), 64'(redirect));
      if (!valid_o) check("nop_when_invalid", instr_o, 64'h0);
      check("req_during_stall", 64'(imem.p_IMEM_Req && valid_o && stall), 64'h0);
      if (prev_valid && prev_stall && !prev_redirect && !prev_reset) begin
        check("stall_hold_valid", 64'(valid_o), 64'h1);
        check("stall_hold_instr", instr_o, prev_instr);
        check("stall_hold_pc", pc_o, prev_pc);
      end
      if (directed && valid_o && nrec < 3) begin
        valid_cyc[nrec] = cyc;
        nrec++;
      end
      if (valid_o && !stall && !redirect) begin
        if (expq.size() == 0) begin
          check("unexpected_valid", 64'(valid_o), 64'h0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("instr", instr_o, e.instr);
          check("instr_pc", pc_o, e.pc);
          consumed++;
        end
      end
      if (imem.p_IMEM_Req && imem.p_IMEM_Ack) begin
        if (!redirect) check("req_addr", imem.p_IMEM_Addr, model_pc);
        out_gen = gen;
        out_pc  = imem.p_IMEM_Addr;
      end
      // Only the response to a request issued since the last redirect/reset is delivered.
      if (imem.p_IMEM_Rsp_Valid && !redirect && out_gen == gen) begin
        expq.push_back('{instr: mem_data(out_pc), pc: out_pc});
        model_pc = out_pc + 64'd4;
      end
      if (redirect) begin
        expq.delete();
        model_pc = {redirect_pc[63:2], 2'b00};
        gen++;
      end
      cyc++;
    end
    prev_valid    = valid_o;
    prev_stall    = stall;
    prev_redirect = redirect;
    prev_reset    = p_reset;
    prev_instr    = instr_o;
    prev_pc       = pc_o;
  end

  initial begin
    p_reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem.p_IMEM_Ack = 1'b0;
    imem.p_IMEM_Rsp_Valid = 1'b0;
    imem.p_IMEM_Rsp_Data = '0;
    pend = 1'b0;
    pend_cnt = 0;
    pend_addr = '0;

    // Directed: immediate ack, one-cycle response, no stall -> valid at cycles 2,4,6.
    stall_pct = 0; redir_pct = 0; rst_pct = 0; ack_pct = 100; max_dly = 1;
    repeat (2) cycle(1'b1);
    repeat (10) cycle(1'b0);
    check("directed_nvalid", 64'(nrec), 64'd3);
    check("directed_valid0_cycle", 64'(valid_cyc[0]), 64'd2);
    check("directed_valid1_cycle", 64'(valid_cyc[1]), 64'd4);
    check("directed_valid2_cycle", 64'(valid_cyc[2]), 64'd6);
    directed = 1'b0;

    // Randomized: stalls, redirects (incl. near-wrap targets), resets, variable latency.
    stall_pct = 30; redir_pct = 6; rst_pct = 1; ack_pct = 70; max_dly = 3;
    repeat (4000) cycle(1'b0);

    stall_pct = 0; redir_pct = 0; rst_pct = 0; ack_pct = 100; max_dly = 1;
    repeat (20) cycle(1'b0);
    check("progress", 64'(consumed >= 200), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
